wrr_sched_ctrl: RTL and testbench
=================================

Name: wrr_sched_ctrl

Overview:
- Weighted round-robin scheduler for the priority-queue output side of the WRR FIFO.
- Watches per-priority "packet available" flags and grants one queue at a time to the dequeue datapath.
- Holds each grant until that packet's end-of-packet is reported.
- Per-queue weights are runtime-configurable; downstream `ready` gates new grants.

Parameters:
- QUEUE_NUM, 8: number of priority queues.
- PRIORITY_BIT, 3: width of a queue index; equals clog2(QUEUE_NUM).
- WEIGHT_BIT, 4: width of a weight and of a credit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q_nonempty  in  QUEUE_NUM  bit i=1: queue i holds at least one complete packet.
- ready  in  1  downstream can accept a new packet.
- pkt_done  in  1  one-cycle pulse: the granted packet finished dequeuing (o_eop).
- cfg_we  in  1  weight write strobe.
- cfg_idx  in  PRIORITY_BIT  queue index to write.
- cfg_weight  in  WEIGHT_BIT  new weight; 0 disables the queue.
- grant_vld  out  1  a grant is active.
- grant_idx  out  PRIORITY_BIT  granted queue, driven to prior_o and rd_ena select.
- grant_onehot  out  QUEUE_NUM  one-hot form of grant_idx; all zero when grant_vld=0.
- err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset values:
  - state=IDLE; grant_vld=0, grant_idx=0, grant_onehot=0, err=0.
  - ptr=0.
  - weight[i]=(i+1) truncated to WEIGHT_BIT; credit[i]=weight[i].
- eligible[i] = q_nonempty[i] & (weight[i]!=0). candidate[i] = eligible[i] & (credit[i]!=0).
- State IDLE:
  - any eligible → ARB next cycle; otherwise stay.
- State ARB:
  - no eligible → IDLE.
  - eligible but no candidate → reload every credit[i]=weight[i]; stay ARB. Costs one cycle.
  - candidate exists and ready=1 → pick the first candidate scanning circularly from ptr upward (wrap QUEUE_NUM-1→0); go to BUSY. Next cycle: grant_vld=1, grant_idx/onehot=pick, credit[pick] decremented by 1.
  - candidate exists and ready=0 → stay ARB; no credit change.
- State BUSY:
  - Grant outputs are held constant; ready and q_nonempty changes are ignored.
  - On pkt_done: grant_vld and onehot drop next cycle; go to ARB.
    - If credit[grant_idx]!=0, ptr=grant_idx.
    - Otherwise ptr=grant_idx+1, wrapping to 0.
- Latency: first grant_vld is 2 cycles after q_nonempty rises from IDLE with ready=1. Minimum back-to-back gap is 1 idle cycle between grants.
- Config writes:
  - cfg_we writes weight[cfg_idx] at the clock edge.
  - Credits are not touched until the next reload.
  - A reload in the same cycle as a write uses the old weight.
  - Writing 0 to the granted queue does not abort the current packet.
- Errors: pkt_done while not in BUSY → err=1 for one cycle; the pulse is otherwise ignored.
- Reset mid-packet: everything returns to reset values immediately (async), including weights.

Optional Feature:
- Macro: WRR_STRICT_PRIO_EN.
- Defined: queue QUEUE_NUM-1 is strict priority.
  - Whenever it is eligible in ARB it wins regardless of ptr or credit.
  - It does not decrement its own credit and does not move ptr.
  - It is also a valid pick when all credits are zero; no reload cycle is needed first.
- Undefined: all queues follow pure WRR as above.

Test Plan:
- Ordering: weights default, q_nonempty=8'b0000_0011 held, ready=1, pkt_done 3 cycles after each grant → grant_idx sequence 0,1,1,0,1,1. One reload cycle before each repeat of 0.
- Weight disable: cfg write idx=1 weight=0, q_nonempty=8'b0000_0010 → stays IDLE, grant_vld=0; write weight=3 → grant_idx=1 after 2 cycles.
- Backpressure: ready=0 with q_nonempty=8'b1000_0000 → grant_vld stays 0 for 20 cycles; ready=1 → grant_vld=1 next cycle, grant_idx=7, grant_onehot=8'b1000_0000.
- Hold and error: in BUSY, drop q_nonempty and ready → grant held until pkt_done. An extra pkt_done in IDLE → err=1 for one cycle.
- Reset mid-grant: rst_n=0 during BUSY → grant_vld=0 and grant_onehot=0 immediately. After release, with q0 and q1 pending, the first grant is idx 0.
- WRR_STRICT_PRIO_EN: q_nonempty=8'b1000_0001, weight7=1 → idx 7 granted on every arbitration and idx 0 is never granted. Clear bit 7 → idx 0 granted.

Source files
------------

// File: rtl/wrr_sched_ctrl_if.sv
// Handshake/config bundle between the WRR scheduler and its dequeue-side environment.
// The scheduler uses the slave modport; the queue/config side drives the master modport.
interface wrr_sched_ctrl_if #(
  parameter int QUEUE_NUM    = 8,
  parameter int PRIORITY_BIT = 3,
  parameter int WEIGHT_BIT   = 4
);

  logic [QUEUE_NUM-1:0]    q_nonempty;
  logic                    ready;
  logic                    pkt_done;
  logic                    cfg_we;
  logic [PRIORITY_BIT-1:0] cfg_idx;
  logic [WEIGHT_BIT-1:0]   cfg_weight;
  logic                    grant_vld;
  logic [PRIORITY_BIT-1:0] grant_idx;
  logic [QUEUE_NUM-1:0]    grant_onehot;
  logic                    err;

  modport master (
    output q_nonempty, ready, pkt_done, cfg_we, cfg_idx, cfg_weight,
    input  grant_vld, grant_idx, grant_onehot, err
  );

  modport slave (
    input  q_nonempty, ready, pkt_done, cfg_we, cfg_idx, cfg_weight,
    output grant_vld, grant_idx, grant_onehot, err
  );

endinterface

// File: rtl/wrr_sched_ctrl.sv
// Weighted round-robin grant controller for the priority-queue output side of the WRR FIFO.
// Optional macro WRR_STRICT_PRIO_EN makes queue QUEUE_NUM-1 a strict-priority queue.
module wrr_sched_ctrl #(
  parameter int QUEUE_NUM    = 8,
  parameter int PRIORITY_BIT = 3,
  parameter int WEIGHT_BIT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  wrr_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

  localparam logic [PRIORITY_BIT-1:0] LAST_IDX = PRIORITY_BIT'(QUEUE_NUM - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [WEIGHT_BIT-1:0]   weight [QUEUE_NUM];
  logic [WEIGHT_BIT-1:0]   credit [QUEUE_NUM];
  logic [PRIORITY_BIT-1:0] ptr;
  logic [QUEUE_NUM-1:0]    eligible;
  logic [QUEUE_NUM-1:0]    candidate;
  logic [PRIORITY_BIT-1:0] pick_idx;
  logic [PRIORITY_BIT-1:0] sel_idx;
  logic                    pick_found;
  logic                    strict_hit;
  logic                    hold_ptr;
  logic                    do_pick;
  logic                    do_reload;
  logic                    do_release;
  int                      scan;

  logic                    grant_vld_q;
  logic [PRIORITY_BIT-1:0] grant_idx_q;
  logic [QUEUE_NUM-1:0]    grant_onehot_q;
  logic                    err_q;

  always_comb begin
    eligible  = '0;
    candidate = '0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      eligible[i]  = bus.q_nonempty[i] & (weight[i] != '0);
      candidate[i] = eligible[i] & (credit[i] != '0);
    end
  end

  // First candidate found scanning circularly upward from ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int k = 0; k < QUEUE_NUM; k++) begin
      scan = int'(ptr) + k;
      if (scan >= QUEUE_NUM) scan = scan - QUEUE_NUM;
      if (!pick_found && candidate[scan[PRIORITY_BIT-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = PRIORITY_BIT'(scan);
      end
    end
  end

`ifdef WRR_STRICT_PRIO_EN
  assign strict_hit = eligible[QUEUE_NUM-1];
  assign hold_ptr   = (grant_idx_q == LAST_IDX);
`else
  assign strict_hit = 1'b0;
  assign hold_ptr   = 1'b0;
`endif

  assign sel_idx = strict_hit ? LAST_IDX : pick_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_pick    = 1'b0;
    do_reload  = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) state_nxt = ARB;
      end
      ARB: begin
        if (!(|eligible)) begin
          state_nxt = IDLE;
        end else if (strict_hit || pick_found) begin
          if (bus.ready) begin
            do_pick   = 1'b1;
            state_nxt = BUSY;
          end
        end else begin
          do_reload = 1'b1;
        end
      end
      BUSY: begin
        if (bus.pkt_done) begin
          do_release = 1'b1;
          state_nxt  = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_NUM; i++) weight[i] <= WEIGHT_BIT'(i + 1);
    end else if (bus.cfg_we) begin
      weight[bus.cfg_idx] <= bus.cfg_weight;
    end
  end

  // A reload samples the registered weights, so a same-cycle write lands only on the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_NUM; i++) credit[i] <= WEIGHT_BIT'(i + 1);
    end else if (do_reload) begin
      for (int i = 0; i < QUEUE_NUM; i++) credit[i] <= weight[i];
    end else if (do_pick && !strict_hit) begin
      credit[pick_idx] <= credit[pick_idx] - WEIGHT_BIT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld_q    <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      err_q          <= 1'b0;
      ptr            <= '0;
    end else begin
      err_q <= bus.pkt_done && (state != BUSY);
      if (do_pick) begin
        grant_vld_q    <= 1'b1;
        grant_idx_q    <= sel_idx;
        grant_onehot_q <= QUEUE_NUM'(1) << sel_idx;
      end else if (do_release) begin
        grant_vld_q    <= 1'b0;
        grant_onehot_q <= '0;
        if (!hold_ptr) begin
          if (credit[grant_idx_q] != '0)  ptr <= grant_idx_q;
          else if (grant_idx_q == LAST_IDX) ptr <= '0;
          else                              ptr <= grant_idx_q + PRIORITY_BIT'(1);
        end
      end
    end
  end

  assign bus.grant_vld    = grant_vld_q;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_wrr_sched_ctrl.sv
// Directed self-checking bench for wrr_sched_ctrl; each task drives one scenario and checks inline.
// Build with WRR_STRICT_PRIO_EN defined to exercise the strict-priority queue scenario.
module tb_wrr_sched_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  wrr_sched_ctrl_if bus ();

  wrr_sched_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.q_nonempty = '0;
    bus.ready      = 1'b0;
    bus.pkt_done   = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_weight = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [3:0] w);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = idx;
    bus.cfg_weight = w;
    tick();
    bus.cfg_we     = 1'b0;
  endtask

  // Returns the number of cycles until grant_vld is seen, or -1 if the budget runs out.
  task automatic wait_grant(input int budget, output int waited);
    int c;
    c      = 0;
    waited = -1;
    while (waited < 0 && c < budget) begin
      c++;
      tick();
      if (bus.grant_vld === 1'b1) waited = c;
    end
  endtask

  task automatic release_grant();
    tick();
    tick();
    bus.pkt_done = 1'b1;
    tick();
    bus.pkt_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.q_nonempty = '0;
    bus.ready      = 1'b0;
    bus.pkt_done   = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_weight = '0;
    #2;
    checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld: got %0b expected 0", bus.grant_vld); end
    checks++; if (bus.grant_idx !== 3'd0) begin fails++; $display("[TB] FAIL reset_idx: got %0d expected 0", bus.grant_idx); end
    checks++; if (bus.grant_onehot !== 8'h00) begin fails++; $display("[TB] FAIL reset_onehot: got %0h expected 0", bus.grant_onehot); end
    checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %0b expected 0", bus.err); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL idle_vld: got %0b expected 0", bus.grant_vld); end
  endtask

  task automatic test_ordering();
    int exp_idx [6];
    int exp_gap [6];
    int waited;
    exp_idx = '{0, 1, 1, 0, 1, 1};
    exp_gap = '{2, 1, 1, 2, 1, 1};
    do_reset();
    bus.q_nonempty = 8'h03;
    bus.ready      = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_grant(10, waited);
      checks++; if (waited != exp_gap[n]) begin fails++; $display("[TB] FAIL ordering_gap[%0d]: got %0d cycles expected %0d", n, waited, exp_gap[n]); end
      checks++; if (bus.grant_idx !== 3'(exp_idx[n])) begin fails++; $display("[TB] FAIL ordering_idx[%0d]: got %0d expected %0d", n, bus.grant_idx, exp_idx[n]); end
      checks++; if (bus.grant_onehot !== (8'h01 << exp_idx[n])) begin fails++; $display("[TB] FAIL ordering_onehot[%0d]: got %0h expected %0h", n, bus.grant_onehot, 8'h01 << exp_idx[n]); end
      release_grant();
      checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL ordering_drop[%0d]: got %0b expected 0", n, bus.grant_vld); end
    end
  endtask

  task automatic test_weight_disable();
    int waited;
    do_reset();
    cfg_write(3'd1, 4'd0);
    bus.q_nonempty = 8'h02;
    bus.ready      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL disabled_vld[%0d]: got %0b expected 0", c, bus.grant_vld); end
    end
    cfg_write(3'd1, 4'd3);
    wait_grant(10, waited);
    checks++; if (waited != 2) begin fails++; $display("[TB] FAIL enable_latency: got %0d cycles expected 2", waited); end
    checks++; if (bus.grant_idx !== 3'd1) begin fails++; $display("[TB] FAIL enable_idx: got %0d expected 1", bus.grant_idx); end
    release_grant();
  endtask

  task automatic test_backpressure_hold_error();
    do_reset();
    bus.q_nonempty = 8'h80;
    bus.ready      = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL backpressure_vld[%0d]: got %0b expected 0", c, bus.grant_vld); end
    end
    bus.ready = 1'b1;
    tick();
    checks++; if (bus.grant_vld !== 1'b1) begin fails++; $display("[TB] FAIL ready_vld: got %0b expected 1", bus.grant_vld); end
    checks++; if (bus.grant_idx !== 3'd7) begin fails++; $display("[TB] FAIL ready_idx: got %0d expected 7", bus.grant_idx); end
    checks++; if (bus.grant_onehot !== 8'h80) begin fails++; $display("[TB] FAIL ready_onehot: got %0h expected 80", bus.grant_onehot); end
    bus.q_nonempty = 8'h00;
    bus.ready      = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.grant_vld !== 1'b1 || bus.grant_idx !== 3'd7) begin fails++; $display("[TB] FAIL hold[%0d]: got vld=%0b idx=%0d expected vld=1 idx=7", c, bus.grant_vld, bus.grant_idx); end
    end
    bus.pkt_done = 1'b1;
    tick();
    bus.pkt_done = 1'b0;
    checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL hold_release: got %0b expected 0", bus.grant_vld); end
    checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL busy_done_err: got %0b expected 0", bus.err); end
    tick();
    bus.pkt_done = 1'b1;
    tick();
    bus.pkt_done = 1'b0;
    checks++; if (bus.err !== 1'b1) begin fails++; $display("[TB] FAIL idle_done_err: got %0b expected 1", bus.err); end
    tick();
    checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL err_pulse_width: got %0b expected 0", bus.err); end
    checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL err_no_grant: got %0b expected 0", bus.grant_vld); end
  endtask

  task automatic test_reset_mid_grant();
    int waited;
    do_reset();
    cfg_write(3'd0, 4'd0);
    bus.q_nonempty = 8'h03;
    bus.ready      = 1'b1;
    wait_grant(10, waited);
    checks++; if (waited != 2 || bus.grant_idx !== 3'd1) begin fails++; $display("[TB] FAIL pre_reset_grant: got wait=%0d idx=%0d expected wait=2 idx=1", waited, bus.grant_idx); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant_vld !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_vld: got %0b expected 0", bus.grant_vld); end
    checks++; if (bus.grant_onehot !== 8'h00) begin fails++; $display("[TB] FAIL async_reset_onehot: got %0h expected 0", bus.grant_onehot); end
    tick();
    rst_n = 1'b1;
    wait_grant(10, waited);
    checks++; if (waited != 2) begin fails++; $display("[TB] FAIL post_reset_latency: got %0d cycles expected 2", waited); end
    checks++; if (bus.grant_idx !== 3'd0) begin fails++; $display("[TB] FAIL post_reset_idx: got %0d expected 0", bus.grant_idx); end
    release_grant();
  endtask

`ifdef WRR_STRICT_PRIO_EN
  task automatic test_strict_prio();
    int waited;
    do_reset();
    cfg_write(3'd7, 4'd1);
    bus.q_nonempty = 8'h81;
    bus.ready      = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(10, waited);
      checks++; if (waited < 0 || bus.grant_idx !== 3'd7) begin fails++; $display("[TB] FAIL strict_idx[%0d]: got wait=%0d idx=%0d expected idx=7", n, waited, bus.grant_idx); end
      if (n == 3) bus.q_nonempty = 8'h01;
      release_grant();
    end
    wait_grant(10, waited);
    checks++; if (waited != 1 || bus.grant_idx !== 3'd0) begin fails++; $display("[TB] FAIL strict_fallback: got wait=%0d idx=%0d expected wait=1 idx=0", waited, bus.grant_idx); end
    release_grant();
  endtask
`else
  task automatic test_wrr_wrap();
    int exp_idx [3];
    int waited;
    exp_idx = '{0, 7, 7};
    do_reset();
    bus.q_nonempty = 8'h81;
    bus.ready      = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_grant(10, waited);
      checks++; if (waited < 0 || bus.grant_idx !== 3'(exp_idx[n])) begin fails++; $display("[TB] FAIL wrap_idx[%0d]: got wait=%0d idx=%0d expected idx=%0d", n, waited, bus.grant_idx, exp_idx[n]); end
      release_grant();
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_ordering();
    test_weight_disable();
    test_backpressure_hold_error();
    test_reset_mid_grant();
`ifdef WRR_STRICT_PRIO_EN
    test_strict_prio();
`else
    test_wrr_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
